mmio_word_fifo: RTL
===================

Name: mmio_word_fifo

Overview:
- Buffering stage directly downstream of the AFU's MMIO write decode.
- Each host MMIO write of the data CSR pushes one 64-bit word.
- Each host MMIO read of the data CSR pops one word, returned in the read-response cycle.
- Provides occupancy and sticky error status so the host can poll the block over MMIO instead of blindly shifting a fixed-depth delay line.

Parameters:
- WIDTH, 64, data word width in bits.
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  MMIO write strobe already decoded for the data CSR address.
- push_data  input  WIDTH  write data (rx.c0.data[63:0]).
- pop  input  1  MMIO read strobe already decoded for the data CSR address.
- pop_data  output  WIDTH  popped word; registered.
- pop_valid  output  1  one-cycle pulse qualifying pop_data.
- clr_sticky  input  1  clears ovf and udf (MMIO write to the status CSR).
- count  output  CNT_W  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- ovf  output  1  sticky: a push was dropped while full.
- udf  output  1  sticky: a pop occurred while empty.
- status  output  64  {ovf, udf, full, empty, zero-pad, count} in bits [63], [62], [61], [60], [59:CNT_W], [CNT_W-1:0].

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, pop_data=0, pop_valid=0, ovf=0, udf=0. Storage contents are not reset.
- Outputs after reset: full=0, empty=1.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push, not full: mem[wr_ptr]<=push_data; wr_ptr++. Visible in count on the next edge.
- Pop latency is exactly 1 cycle. Pop asserted at edge N gives pop_valid=1 and pop_data valid in cycle N+1, which matches the MMIO read-response timing.
- Pop, not empty: pop_data<=mem[rd_ptr]; rd_ptr++.
- Pop while empty: pop_valid=1, pop_data=0, udf<=1; pointers unchanged.
- Push while full and no pop: word dropped, ovf<=1; pointers unchanged.
- Push and pop in the same cycle, 0<count<DEPTH: both succeed; count unchanged.
- Push and pop in the same cycle, full: both succeed (pop frees the slot in the same edge); count stays DEPTH; ovf not set.
- Push and pop in the same cycle, empty: no bypass. Push is accepted, pop underflows (pop_data=0, udf=1), count becomes 1.
- count arithmetic: count + accepted_push - accepted_pop, never outside 0..DEPTH.
- clr_sticky: ovf and udf are cleared at the edge. If a new overflow or underflow event occurs in the same cycle, the set wins.
- pop_data holds its last value when pop_valid=0.
- Reset mid-operation: all state returns to reset values immediately; any in-flight pop_valid is lost.

Optional Feature:
- MMIO_WORD_FIFO_STATS_EN defined:
  - Adds outputs push_total[31:0] and pop_total[31:0].
  - They count accepted pushes and accepted pops respectively, saturate at 32'hFFFF_FFFF, and reset to 0.
  - clr_sticky also clears both counters.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Decomposition:
- Package mmio_word_fifo_pkg holds:
  - CSR address constants: MMIO_FIFO_DATA_ADDR=16'h0020, MMIO_FIFO_STATUS_ADDR=16'h0022.
  - Status bit-index constants: STAT_OVF=63, STAT_UDF=62, STAT_FULL=61, STAT_EMPTY=60.
  - Packed typedef t_fifo_status.
- One sub-module, mmio_word_fifo_mem:
  - DEPTH x WIDTH storage with one synchronous write port and one synchronous read port.
  - No reset.
  - Keeps the storage inferable as MLAB/M20K.
- Pointer, count and flag logic stays in the top module.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles, then pop three times:
  - pop_data is 0x1111, 0x2222, 0x3333, each one cycle after its pop.
  - count goes 3 -> 0; empty=1.
- Fill with 8 pushes (0x10..0x17), then push 0xDEAD:
  - full=1, count=8, ovf=1.
  - Drain order is 0x10..0x17; 0xDEAD never appears.
- Pop on empty after reset:
  - pop_valid=1, pop_data=0, udf=1, status[62]=1.
  - Pulse clr_sticky: udf=0.
- Full FIFO, push 0xAA and pop in the same cycle:
  - pop_data = oldest word, count stays 8, ovf=0.
  - 0xAA emerges last.
- Wrap-around: 20 interleaved push/pop pairs with data = index:
  - every pop returns the matching index; count never exceeds 1.
- Assert rst mid-stream with count=5:
  - count=0, empty=1, pop_valid=0 immediately.
  - Next push/pop of 0x55 returns 0x55.
- With MMIO_WORD_FIFO_STATS_EN defined, after the above: push_total and pop_total equal the number of accepted operations.

Source files
------------

// File: rtl/mmio_word_fifo_pkg.sv
// Shared constants and the status-word layout for the MMIO word FIFO.
package mmio_word_fifo_pkg;

   localparam logic [15:0] MMIO_FIFO_DATA_ADDR   = 16'h0020;
   localparam logic [15:0] MMIO_FIFO_STATUS_ADDR = 16'h0022;

   localparam int STAT_OVF   = 63;
   localparam int STAT_UDF   = 62;
   localparam int STAT_FULL  = 61;
   localparam int STAT_EMPTY = 60;

   // info carries the zero-extended occupancy count in its low bits
   typedef struct packed {
      logic        ovf;
      logic        udf;
      logic        full;
      logic        empty;
      logic [59:0] info;
   } t_fifo_status;

endpackage

// File: rtl/mmio_word_fifo_if.sv
// Host-side MMIO signals of the word FIFO; MMIO_WORD_FIFO_STATS_EN adds the
// accepted-operation totals.
interface mmio_word_fifo_if #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
);
   logic             push;
   logic [WIDTH-1:0] push_data;
   logic             pop;
   logic [WIDTH-1:0] pop_data;
   logic             pop_valid;
   logic             clr_sticky;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             ovf;
   logic             udf;
   logic [63:0]      status;
`ifdef MMIO_WORD_FIFO_STATS_EN
   logic [31:0]      push_total;
   logic [31:0]      pop_total;

   modport master (
      output push, push_data, pop, clr_sticky,
      input  pop_data, pop_valid, count, full, empty, ovf, udf, status,
             push_total, pop_total
   );
   modport slave (
      input  push, push_data, pop, clr_sticky,
      output pop_data, pop_valid, count, full, empty, ovf, udf, status,
             push_total, pop_total
   );
`else
   modport master (
      output push, push_data, pop, clr_sticky,
      input  pop_data, pop_valid, count, full, empty, ovf, udf, status
   );
   modport slave (
      input  push, push_data, pop, clr_sticky,
      output pop_data, pop_valid, count, full, empty, ovf, udf, status
   );
`endif
endinterface

// File: rtl/mmio_word_fifo_mem.sv
// DEPTH x WIDTH storage, one synchronous write port and one registered read
// port; read returns the old word when both ports hit the same address.
module mmio_word_fifo_mem #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: no reset on the array or read register, otherwise the tools cannot map it to MLAB/M20K.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/mmio_word_fifo.sv
// MMIO-facing word FIFO with occupancy and sticky ovf/udf status.
// Define MMIO_WORD_FIFO_STATS_EN to add saturating push/pop totals.
module mmio_word_fifo
   import mmio_word_fifo_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input logic             clk,
   input logic             rst,
   mmio_word_fifo_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             pop_valid_q;
   logic             zero_q;
   logic             ovf_q, udf_q;
   logic [WIDTH-1:0] rd_data;
   logic             full, empty;
   logic             acc_push, acc_pop, ovf_evt, udf_evt;
   t_fifo_status     stat;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign acc_push = bus.push && (!full || bus.pop);
   assign acc_pop  = bus.pop && !empty;
   assign ovf_evt  = bus.push && full && !bus.pop;
   assign udf_evt  = bus.pop && empty;

   mmio_word_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PTR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (acc_push),
      .wr_addr (wr_ptr),
      .wr_data (bus.push_data),
      .rd_en   (acc_pop),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         pop_valid_q <= 1'b0;
         zero_q      <= 1'b1;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
      end else begin
         if (acc_push) wr_ptr <= wr_ptr + 1'b1;
         if (acc_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({acc_push, acc_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         pop_valid_q <= bus.pop;
         // zero_q masks the unreset read register after reset and on underflow
         if (bus.pop) zero_q <= empty;
         ovf_q <= (ovf_q && !bus.clr_sticky) || ovf_evt;
         udf_q <= (udf_q && !bus.clr_sticky) || udf_evt;
      end
   end

   // NOTE: every field gets a default first so no latch can be inferred.
   always_comb begin
      stat       = '0;
      stat.ovf   = ovf_q;
      stat.udf   = udf_q;
      stat.full  = full;
      stat.empty = empty;
      stat.info  = 60'(count_q);
   end

   assign bus.pop_data  = zero_q ? '0 : rd_data;
   assign bus.pop_valid = pop_valid_q;
   assign bus.count     = count_q;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.ovf       = ovf_q;
   assign bus.udf       = udf_q;
   assign bus.status    = stat;

`ifdef MMIO_WORD_FIFO_STATS_EN
   logic [31:0] push_total_q, pop_total_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         push_total_q <= '0;
         pop_total_q  <= '0;
      end else if (bus.clr_sticky) begin
         push_total_q <= '0;
         pop_total_q  <= '0;
      end else begin
         if (acc_push && push_total_q != '1) push_total_q <= push_total_q + 1'b1;
         if (acc_pop  && pop_total_q  != '1) pop_total_q  <= pop_total_q + 1'b1;
      end
   end

   assign bus.push_total = push_total_q;
   assign bus.pop_total  = pop_total_q;
`endif

endmodule
